// File: rtl/rt_top.sv
// UART boot/loader front end: announces readiness, loads a fixed-length byte
// stream into a buffer, then returns a modulo-256 checksum and flags done.
module rt_top #(
  parameter int unsigned CLK_PER_HALF_BIT = 434,
  parameter int unsigned NUM_BYTES        = 1300,
  parameter int unsigned ADDR_W           = 11,
  parameter logic [7:0]  READY_BYTE       = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              txd,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              done
);

  localparam int unsigned BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned TMR_W    = $clog2(BIT_CLKS);
  localparam int unsigned CNT_W    = $clog2(NUM_BYTES + 1);
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {ST_ANNOUNCE, ST_RECV, ST_SEND_SUM, ST_WAIT_TX, ST_DONE} ctl_state_t;

  rx_state_t        rx_state;
  logic             rx_meta, rx_sync, rx_prev;
  logic [TMR_W-1:0] rx_tmr;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_valid;
  logic [7:0]       rx_byte;

  logic             tx_busy;
  logic [8:0]       tx_shift;
  logic [3:0]       tx_idx;
  logic [TMR_W-1:0] tx_tmr;
  logic             tx_start_c;
  logic [7:0]       tx_data_c;

  ctl_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sum;
  logic             wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [7:0]       mem [2**ADDR_W];

  // Two-flop synchronizer plus one more stage for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver: confirm start at half bit, then sample each bit mid-period
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tmr   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_tmr   <= '0;
          end
        end
        RX_START: begin
          if (rx_tmr == HALF_LAST) begin
            rx_tmr   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_tmr <= rx_tmr + TMR_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_tmr == BIT_LAST) begin
            rx_tmr   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_tmr <= rx_tmr + TMR_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_tmr == BIT_LAST) begin
            rx_tmr   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else begin
            rx_tmr <= rx_tmr + TMR_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: start bit driven on acceptance, stop bit is the shifted-in 1
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      tx_shift <= '1;
      tx_idx   <= '0;
      tx_tmr   <= '0;
    end else if (!tx_busy) begin
      if (tx_start_c) begin
        tx_busy  <= 1'b1;
        txd      <= 1'b0;
        tx_shift <= {1'b1, tx_data_c};
        tx_idx   <= '0;
        tx_tmr   <= '0;
      end
    end else if (tx_tmr == BIT_LAST) begin
      tx_tmr <= '0;
      if (tx_idx == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        txd      <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_idx   <= tx_idx + 4'd1;
      end
    end else begin
      tx_tmr <= tx_tmr + TMR_W'(1);
    end
  end

  assign tx_start_c = (state == ST_ANNOUNCE) || ((state == ST_SEND_SUM) && !tx_busy);
  assign tx_data_c  = (state == ST_ANNOUNCE) ? READY_BYTE : sum;
  assign wr_en_c    = (state == ST_RECV) && rx_valid;
  assign wr_addr_c  = ADDR_W'(cnt);

  // Load sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ANNOUNCE;
      cnt   <= '0;
      sum   <= '0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_ANNOUNCE: state <= ST_RECV;
        ST_RECV: begin
          if (rx_valid) begin
            sum <= sum + rx_byte;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) state <= ST_SEND_SUM;
          end
        end
        ST_SEND_SUM: if (!tx_busy) state <= ST_WAIT_TX;
        ST_WAIT_TX: begin
          if (!tx_busy) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_ANNOUNCE;
      endcase
    end
  end

  // Byte buffer survives reset; read port is registered
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= rx_byte;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_rt_top.sv
// Directed bench for rt_top using a short bit period and a 3-byte stream.
module tb_rt_top;

  localparam int unsigned HALF = 4;
  localparam int unsigned FULL = 2 * HALF;
  localparam int unsigned NB   = 3;
  localparam int unsigned AW   = 4;

  logic          clk;
  logic          rst;
  logic          rxd;
  logic          txd;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          done;

  int total = 0;
  int bad   = 0;

  logic [8:0] tx_q[$];
  logic       m_act = 1'b0;
  int         m_cnt = 0;
  int         m_bit = 0;
  logic [9:0] m_sh  = '0;

  rt_top #(
    .CLK_PER_HALF_BIT(HALF),
    .NUM_BYTES(NB),
    .ADDR_W(AW),
    .READY_BYTE(8'hAA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .txd(txd),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host-side decoder of txd; queue entry is {frame_ok, data}
  always @(negedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
    end else if (!m_act) begin
      if (txd === 1'b0) begin
        m_act <= 1'b1;
        m_cnt <= HALF - 1;
        m_bit <= 0;
      end
    end else if (m_cnt == 1) begin
      m_sh[m_bit] <= txd;
      m_cnt <= FULL;
      m_bit <= m_bit + 1;
      if (m_bit == 9) begin
        m_act <= 1'b0;
        tx_q.push_back({(txd === 1'b1) && (m_sh[0] === 1'b0), m_sh[8:1]});
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rxd = 1'b0;
    repeat (FULL) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (FULL) tick();
    end
    rxd = stop_v;
    repeat (FULL) tick();
    rxd = 1'b1;
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp_b);
    logic [8:0] f;
    for (int k = 0; k < 400 && tx_q.size() == 0; k++) tick();
    chk({tag, "_seen"}, 32'(tx_q.size() != 0), 32'd1);
    if (tx_q.size() != 0) begin
      f = tx_q.pop_front();
      chk({tag, "_frame"}, 32'(f[8]), 32'd1);
      chk(tag, 32'(f[7:0]), 32'(exp_b));
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 100 && done !== 1'b1; k++) tick();
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp_b);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp_b));
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rd_addr = '0;
    repeat (3) tick();
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_done", 32'(done), 32'd0);

    // Announce byte and quiet line afterwards
    rst = 1'b0;
    wait_tx("announce", 8'hAA);
    repeat (3 * FULL) tick();
    chk("idle_no_tx", 32'(tx_q.size()), 32'd0);
    chk("idle_txd", 32'(txd), 32'd1);
    chk("idle_done", 32'(done), 32'd0);

    // Good byte, framing error, short glitch, then two back-to-back bytes
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (FULL) tick();
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (2 * FULL) tick();
    chk("glitch_no_tx", 32'(tx_q.size()), 32'd0);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h10, 1'b1);
    wait_tx("sum_a", 8'h10);
    wait_done("done_a");
    rd_chk("buf_a0", 4'd0, 8'h01);
    rd_chk("buf_a1", 4'd1, 8'hFF);
    rd_chk("buf_a2", 4'd2, 8'h10);

    // Bytes after done are ignored
    send_byte(8'h77, 1'b1);
    repeat (4 * FULL) tick();
    chk("post_done", 32'(done), 32'd1);
    chk("post_no_tx", 32'(tx_q.size()), 32'd0);
    rd_chk("post_buf0", 4'd0, 8'h01);

    // Reset, then interrupt the fresh announce frame
    rst = 1'b1;
    tick();
    chk("rst2_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3 * FULL) tick();
    rst = 1'b1;
    tick();
    chk("midtx_txd", 32'(txd), 32'd1);
    chk("midtx_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    wait_tx("announce_b", 8'hAA);

    // Partial stream then reset: count and sum must restart
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_tx("announce_c", 8'hAA);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    wait_tx("sum_c", 8'h9C);
    wait_done("done_c");
    rd_chk("buf_c0", 4'd0, 8'h12);
    rd_chk("buf_c1", 4'd1, 8'h34);
    rd_chk("buf_c2", 4'd2, 8'h56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
